// File: rtl/mem_issue_queue_pkg.sv
// mem_issue_queue_pkg: shared types and circular age helper for the memory issue queue
package mem_issue_queue_pkg;
  localparam int AL_SIZE = 32;
  localparam int AL_W = $clog2(AL_SIZE);
  localparam int PREG_W = 6;
  typedef enum logic {READ = 1'b0, WRITE = 1'b1} mem_access_t;
  typedef struct packed {
    logic              valid;
    mem_access_t       mtype;
    logic [31:0]       imm;
    logic [PREG_W-1:0] rd;
    logic [PREG_W-1:0] rs1;
    logic [PREG_W-1:0] rs2;
    logic              rs1_rdy;
    logic              rs2_rdy;
    logic [AL_W-1:0]   al_addr;
  } miq_entry_t;
  function automatic logic al_older(input logic [AL_W-1:0] a, input logic [AL_W-1:0] r, input logic [AL_W-1:0] back);
    logic [AL_W-1:0] da;
    logic [AL_W-1:0] dr;
    da = a - back;
    dr = r - back;
    return da < dr;
  endfunction
endpackage

// File: rtl/mem_issue_queue_wakeup_cam.sv
// mem_issue_queue_wakeup_cam: compares operand tags against the writeback buses; tag 0 always hits
module mem_issue_queue_wakeup_cam #(
  parameter int N = 8,
  parameter int N_WB = 4,
  parameter int W = 6
) (
  input  logic [N-1:0][W-1:0]    i_tag,
  input  logic [N_WB-1:0]        i_wb_valid,
  input  logic [N_WB-1:0]        i_wb_uses_rd,
  input  logic [N_WB-1:0][W-1:0] i_wb_rd,
  output logic [N-1:0]           o_hit
);
  // one hit bit per tag: zero tag or any live writeback producing it
  always_comb begin
    for (int i = 0; i < N; i++) begin
      o_hit[i] = i_tag[i] == '0;
      for (int w = 0; w < N_WB; w++)
        if (i_wb_valid[w] && i_wb_uses_rd[w] && i_wb_rd[w] == i_tag[i]) o_hit[i] = 1'b1;
    end
  end
endmodule

// File: rtl/mem_issue_queue.sv
// mem_issue_queue: in-order two-wide memory issue queue with writeback wakeup and recall squash
module mem_issue_queue import mem_issue_queue_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int N_WB = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   i_d_valid,
  input  logic [1:0]                   i_d_mem_access_type,
  input  logic [1:0][31:0]             i_d_imm,
  input  logic [1:0][PREG_W-1:0]       i_d_rd,
  input  logic [1:0][PREG_W-1:0]       i_d_rs1,
  input  logic [1:0][PREG_W-1:0]       i_d_rs2,
  input  logic [1:0]                   i_d_rs1_rdy,
  input  logic [1:0]                   i_d_rs2_rdy,
  input  logic [1:0][AL_W-1:0]         i_d_al_addr,
  output logic                         o_d_ready,
  input  logic [N_WB-1:0]              i_wb_valid,
  input  logic [N_WB-1:0]              i_wb_uses_rd,
  input  logic [N_WB-1:0][PREG_W-1:0]  i_wb_rd,
  input  logic                         i_recall,
  input  logic [AL_W-1:0]              i_new_front,
  input  logic [AL_W-1:0]              i_old_front,
  input  logic [AL_W-1:0]              i_back,
  output logic [1:0]                   o_miq_valid,
  output logic [1:0]                   o_miq_mem_access_type,
  output logic [1:0][31:0]             o_miq_imm,
  output logic [1:0][PREG_W-1:0]       o_miq_rd,
  output logic [1:0][PREG_W-1:0]       o_miq_rs1,
  output logic [1:0][PREG_W-1:0]       o_miq_rs2,
  output logic [1:0][AL_W-1:0]         o_miq_al_addr,
  output logic [$clog2(DEPTH):0]       o_count
);
  localparam int IW = $clog2(DEPTH);
  miq_entry_t                        r_q [DEPTH];
  logic [IW-1:0]                     r_head;
  logic [IW-1:0]                     r_tail;
  logic [IW:0]                       r_count;
  logic [2*DEPTH+3:0][PREG_W-1:0]    w_tag;
  logic [2*DEPTH+3:0]                w_hit;
  miq_entry_t                        w_e [2];
  miq_entry_t                        w_new [2];
  logic [IW-1:0]                     w_hidx [2];
  logic [IW-1:0]                     w_slot [2];
  logic [1:0]                        w_rdy;
  logic [1:0]                        w_iss;
  logic [1:0]                        w_dv;
  logic [IW:0]                       w_n_iss;
  logic [IW:0]                       w_n_disp;
  logic [IW:0]                       w_n_surv;
  logic [IW:0]                       w_keep;
  logic [DEPTH-1:0]                  w_kill;

  assign o_d_ready = r_count <= (IW+1)'(DEPTH - 2);
  assign o_count = r_count;

  // gather stored and incoming operand tags for one shared wakeup compare
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_tag[i] = r_q[i].rs1;
      w_tag[DEPTH+i] = r_q[i].rs2;
    end
    for (int l = 0; l < 2; l++) begin
      w_tag[2*DEPTH+l] = i_d_rs1[l];
      w_tag[2*DEPTH+2+l] = i_d_rs2[l];
    end
  end

  mem_issue_queue_wakeup_cam #(.N(2*DEPTH+4), .N_WB(N_WB), .W(PREG_W)) u_cam (
    .i_tag(w_tag),
    .i_wb_valid(i_wb_valid),
    .i_wb_uses_rd(i_wb_uses_rd),
    .i_wb_rd(i_wb_rd),
    .o_hit(w_hit)
  );

  // in-order select of the two oldest entries plus dispatch slot and payload
  always_comb begin
    w_dv = (o_d_ready && !i_recall) ? i_d_valid : 2'b00;
    w_slot[0] = r_tail;
    w_slot[1] = r_tail + IW'(w_dv[0]);
    for (int k = 0; k < 2; k++) begin
      w_hidx[k] = r_head + IW'(k);
      w_e[k] = r_q[w_hidx[k]];
      w_rdy[k] = w_e[k].valid && w_e[k].rs1_rdy && (w_e[k].mtype == READ || w_e[k].rs2_rdy);
      w_new[k] = '{valid: 1'b1, mtype: mem_access_t'(i_d_mem_access_type[k]), imm: i_d_imm[k],
                   rd: i_d_rd[k], rs1: i_d_rs1[k], rs2: i_d_rs2[k],
                   rs1_rdy: i_d_rs1_rdy[k] | w_hit[2*DEPTH+k],
                   rs2_rdy: i_d_rs2_rdy[k] | w_hit[2*DEPTH+2+k], al_addr: i_d_al_addr[k]};
    end
    w_iss = {w_rdy[1] & w_rdy[0], w_rdy[0]};
    w_n_iss = (IW+1)'(w_iss[0]) + (IW+1)'(w_iss[1]);
    w_n_disp = (IW+1)'(w_dv[0]) + (IW+1)'(w_dv[1]);
  end

  // survivors of a recall form a prefix from head, so their count locates the new tail
  always_comb begin
    w_n_surv = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_kill[i] = !al_older(r_q[i].al_addr, i_new_front, i_back);
      w_n_surv = w_n_surv + (IW+1)'(r_q[i].valid && !w_kill[i]);
    end
    w_keep = (w_n_surv > w_n_iss) ? w_n_surv : w_n_iss;
  end

  // entry storage: wakeup, pop, squash, then dispatch writes at tail
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_hit[i]) r_q[i].rs1_rdy <= 1'b1;
        if (w_hit[DEPTH+i]) r_q[i].rs2_rdy <= 1'b1;
        if (i_recall && w_kill[i]) r_q[i].valid <= 1'b0;
      end
      for (int k = 0; k < 2; k++) begin
        if (w_iss[k]) r_q[w_hidx[k]].valid <= 1'b0;
        if (w_dv[k]) r_q[w_slot[k]] <= w_new[k];
      end
      r_head <= r_head + w_n_iss[IW-1:0];
      r_tail <= i_recall ? r_head + w_keep[IW-1:0] : r_tail + w_n_disp[IW-1:0];
      r_count <= i_recall ? w_keep - w_n_iss : r_count + w_n_disp - w_n_iss;
    end
  end

  // issue register: valid follows select, payload holds when nothing issues
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_miq_valid <= '0;
      o_miq_mem_access_type <= '0;
      o_miq_imm <= '0;
      o_miq_rd <= '0;
      o_miq_rs1 <= '0;
      o_miq_rs2 <= '0;
      o_miq_al_addr <= '0;
    end else begin
      o_miq_valid <= w_iss;
      for (int k = 0; k < 2; k++) begin
        if (w_iss[k]) begin
          o_miq_mem_access_type[k] <= w_e[k].mtype;
          o_miq_imm[k] <= w_e[k].imm;
          o_miq_rd[k] <= w_e[k].rd;
          o_miq_rs1[k] <= w_e[k].rs1;
          o_miq_rs2[k] <= w_e[k].rs2;
          o_miq_al_addr[k] <= w_e[k].al_addr;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_issue_queue.sv
// tb_mem_issue_queue: vector table, directed corner sequences and random traffic against a queue model
module tb_mem_issue_queue;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       d_valid, d_type, d_r1r, d_r2r;
  logic [1:0][31:0] d_imm;
  logic [1:0][5:0]  d_rd, d_rs1, d_rs2;
  logic [1:0][4:0]  d_al;
  logic [3:0]       wb_v, wb_u;
  logic [3:0][5:0]  wb_rd;
  logic             recall;
  logic [4:0]       nf, of, bk;
  logic             o_d_ready;
  logic [1:0]       o_miq_valid, o_miq_type;
  logic [1:0][31:0] o_miq_imm;
  logic [1:0][5:0]  o_miq_rd, o_miq_rs1, o_miq_rs2;
  logic [1:0][4:0]  o_miq_al;
  logic [3:0]       o_count;

  mem_issue_queue #(.DEPTH(DEPTH), .N_WB(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_d_valid(d_valid), .i_d_mem_access_type(d_type), .i_d_imm(d_imm), .i_d_rd(d_rd),
    .i_d_rs1(d_rs1), .i_d_rs2(d_rs2), .i_d_rs1_rdy(d_r1r), .i_d_rs2_rdy(d_r2r), .i_d_al_addr(d_al),
    .o_d_ready(o_d_ready), .i_wb_valid(wb_v), .i_wb_uses_rd(wb_u), .i_wb_rd(wb_rd),
    .i_recall(recall), .i_new_front(nf), .i_old_front(of), .i_back(bk),
    .o_miq_valid(o_miq_valid), .o_miq_mem_access_type(o_miq_type), .o_miq_imm(o_miq_imm),
    .o_miq_rd(o_miq_rd), .o_miq_rs1(o_miq_rs1), .o_miq_rs2(o_miq_rs2), .o_miq_al_addr(o_miq_al),
    .o_count(o_count)
  );

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic        typ;
    logic [31:0] imm;
    logic [5:0]  rd, rs1, rs2;
    logic        r1, r2;
    logic [4:0]  al;
  } ment_t;

  ment_t      mq[$];
  ment_t      e_out[2];
  logic [1:0] e_valid;

  typedef struct {
    logic [1:0]  dv, typ, r1r, r2r;
    logic [5:0]  rs1, rs2;
    logic [31:0] imm0, imm1;
    logic        wv;
    logic [5:0]  wrd;
    logic [1:0]  ev;
    logic [31:0] ei0, ei1;
    int          ec;
  } vec_t;
  vec_t tv[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit woke(input logic [5:0] t);
    if (t == 6'd0) return 1'b1;
    for (int w = 0; w < 4; w++) if (wb_v[w] && wb_u[w] && wb_rd[w] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit mrdy(input ment_t e);
    return e.r1 && (!e.typ || e.r2);
  endfunction

  function automatic bit survives(input logic [4:0] al);
    return ((int'(al) - int'(bk) + 32) % 32) < ((int'(nf) - int'(bk) + 32) % 32);
  endfunction

  function automatic logic [63:0] pk(input ment_t e);
    return {8'd0, e.typ, e.imm, e.rd, e.rs1, e.rs2, e.al};
  endfunction

  task automatic idle();
    d_valid = '0; d_type = '0; d_r1r = '0; d_r2r = '0; d_imm = '0; d_rd = '0;
    d_rs1 = '0; d_rs2 = '0; d_al = '0; wb_v = '0; wb_u = '0; wb_rd = '0;
    recall = 1'b0; nf = '0; of = '0; bk = '0;
  endtask

  task automatic disp(input int l, input logic typ, input logic [5:0] rs1, input logic r1r,
                      input logic [5:0] rs2, input logic r2r, input logic [31:0] imm, input logic [4:0] al);
    d_valid[l] = 1'b1; d_type[l] = typ; d_rs1[l] = rs1; d_r1r[l] = r1r; d_rs2[l] = rs2;
    d_r2r[l] = r2r; d_imm[l] = imm; d_rd[l] = imm[5:0]; d_al[l] = al;
  endtask

  task automatic wake(input logic [5:0] t);
    wb_v[0] = 1'b1; wb_u[0] = 1'b1; wb_rd[0] = t;
  endtask

  task automatic model_clear();
    mq.delete();
    e_valid = '0;
    for (int k = 0; k < 2; k++) e_out[k] = '{default: '0};
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_clear();
    chk("rst_count", o_count, 0);
    chk("rst_ready", o_d_ready, 1);
    chk("rst_valid", o_miq_valid, 0);
  endtask

  task automatic step();
    int    n;
    int    sz0;
    ment_t e;
    sz0 = mq.size();
    chk("d_ready", o_d_ready, sz0 <= DEPTH - 2);
    n = 0;
    if (sz0 > 0 && mrdy(mq[0])) n = (sz0 > 1 && mrdy(mq[1])) ? 2 : 1;
    e_valid = '0;
    for (int k = 0; k < n; k++) begin
      e_valid[k] = 1'b1;
      e_out[k] = mq[k];
    end
    foreach (mq[i]) begin
      if (woke(mq[i].rs1)) mq[i].r1 = 1'b1;
      if (woke(mq[i].rs2)) mq[i].r2 = 1'b1;
    end
    repeat (n) void'(mq.pop_front());
    if (recall) begin
      for (int i = mq.size() - 1; i >= 0; i--) if (!survives(mq[i].al)) mq.delete(i);
    end else if (sz0 <= DEPTH - 2) begin
      for (int l = 0; l < 2; l++) if (d_valid[l]) begin
        e.typ = d_type[l]; e.imm = d_imm[l]; e.rd = d_rd[l]; e.rs1 = d_rs1[l]; e.rs2 = d_rs2[l];
        e.r1 = d_r1r[l] | woke(d_rs1[l]); e.r2 = d_r2r[l] | woke(d_rs2[l]); e.al = d_al[l];
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    chk("mdl_valid", o_miq_valid, e_valid);
    for (int k = 0; k < 2; k++)
      chk($sformatf("mdl_payload%0d", k),
          {8'd0, o_miq_type[k], o_miq_imm[k], o_miq_rd[k], o_miq_rs1[k], o_miq_rs2[k], o_miq_al[k]},
          pk(e_out[k]));
    chk("mdl_count", o_count, mq.size());
  endtask

  initial begin
    logic [4:0] al_next;
    tv[0] = '{2'b11, 2'b00, 2'b11, 2'b00, 6'd5, 6'd0, 32'd4,  32'd8,  1'b0, 6'd0, 2'b00, 32'd0,  32'd0,  2};
    tv[1] = '{2'b00, 2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 32'd0,  32'd0,  1'b0, 6'd0, 2'b11, 32'd4,  32'd8,  0};
    tv[2] = '{2'b11, 2'b01, 2'b11, 2'b00, 6'd5, 6'd9, 32'd12, 32'd16, 1'b0, 6'd0, 2'b00, 32'd4,  32'd8,  2};
    tv[3] = '{2'b00, 2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 32'd0,  32'd0,  1'b0, 6'd0, 2'b00, 32'd4,  32'd8,  2};
    tv[4] = '{2'b00, 2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 32'd0,  32'd0,  1'b1, 6'd9, 2'b00, 32'd4,  32'd8,  2};
    tv[5] = '{2'b00, 2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 32'd0,  32'd0,  1'b0, 6'd0, 2'b11, 32'd12, 32'd16, 0};
    tv[6] = '{2'b01, 2'b00, 2'b00, 2'b00, 6'd7, 6'd0, 32'd20, 32'd0,  1'b1, 6'd7, 2'b00, 32'd12, 32'd16, 1};
    tv[7] = '{2'b00, 2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 32'd0,  32'd0,  1'b0, 6'd0, 2'b01, 32'd20, 32'd16, 0};
    tv[8] = '{2'b10, 2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 32'd0,  32'd24, 1'b0, 6'd0, 2'b00, 32'd20, 32'd16, 1};
    tv[9] = '{2'b00, 2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 32'd0,  32'd0,  1'b0, 6'd0, 2'b01, 32'd24, 32'd16, 0};

    do_reset();
    for (int r = 0; r < 10; r++) begin
      idle();
      d_valid = tv[r].dv; d_type = tv[r].typ; d_r1r = tv[r].r1r; d_r2r = tv[r].r2r;
      d_rs1 = {tv[r].rs1, tv[r].rs1}; d_rs2 = {tv[r].rs2, tv[r].rs2};
      d_imm = {tv[r].imm1, tv[r].imm0}; d_rd = {tv[r].imm1[5:0], tv[r].imm0[5:0]};
      if (tv[r].wv) wake(tv[r].wrd);
      step();
      chk($sformatf("vec%0d_valid", r), o_miq_valid, tv[r].ev);
      chk($sformatf("vec%0d_imm0", r), o_miq_imm[0], tv[r].ei0);
      chk($sformatf("vec%0d_imm1", r), o_miq_imm[1], tv[r].ei1);
      chk($sformatf("vec%0d_count", r), o_count, tv[r].ec);
    end

    do_reset();
    for (int c = 0; c < 4; c++) begin
      idle();
      disp(0, 1'b0, 6'd10, 1'b0, 6'd0, 1'b0, 32'(100 + 2 * c), 5'(2 * c));
      disp(1, 1'b0, 6'd10, 1'b0, 6'd0, 1'b0, 32'(101 + 2 * c), 5'(2 * c + 1));
      step();
    end
    chk("full_count", o_count, 8);
    chk("full_ready", o_d_ready, 0);
    idle();
    disp(0, 1'b0, 6'd0, 1'b1, 6'd0, 1'b0, 32'd555, 5'd9);
    disp(1, 1'b0, 6'd0, 1'b1, 6'd0, 1'b0, 32'd556, 5'd10);
    step();
    chk("full_ignored", o_count, 8);
    idle();
    wake(6'd10);
    step();
    for (int c = 0; c < 4; c++) begin
      idle();
      step();
      chk($sformatf("drain%0d_valid", c), o_miq_valid, 2'b11);
      chk($sformatf("drain%0d_imm0", c), o_miq_imm[0], 32'(100 + 2 * c));
    end
    idle();
    step();
    chk("empty_no_issue", o_miq_valid, 2'b00);
    idle();
    disp(0, 1'b0, 6'd0, 1'b1, 6'd0, 1'b0, 32'd200, 5'd8);
    disp(1, 1'b1, 6'd0, 1'b1, 6'd0, 1'b1, 32'd201, 5'd9);
    step();
    idle();
    step();
    chk("wrap_valid", o_miq_valid, 2'b11);
    chk("wrap_imm1", o_miq_imm[1], 32'd201);

    idle();
    disp(0, 1'b0, 6'd1, 1'b1, 6'd0, 1'b0, 32'd300, 5'd10);
    disp(1, 1'b0, 6'd1, 1'b1, 6'd0, 1'b0, 32'd301, 5'd11);
    step();
    idle();
    step();
    chk("pre_async_valid", o_miq_valid, 2'b11);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_valid", o_miq_valid, 2'b00);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_clear();
    chk("async_rst_count", o_count, 0);

    do_reset();
    idle();
    disp(0, 1'b0, 6'd11, 1'b0, 6'd0, 1'b0, 32'd1, 5'd1);
    disp(1, 1'b0, 6'd11, 1'b0, 6'd0, 1'b0, 32'd2, 5'd2);
    step();
    idle();
    disp(0, 1'b0, 6'd11, 1'b0, 6'd0, 1'b0, 32'd3, 5'd3);
    disp(1, 1'b0, 6'd11, 1'b0, 6'd0, 1'b0, 32'd4, 5'd4);
    step();
    idle();
    disp(0, 1'b0, 6'd0, 1'b1, 6'd0, 1'b0, 32'd5, 5'd5);
    disp(1, 1'b0, 6'd0, 1'b1, 6'd0, 1'b0, 32'd6, 5'd6);
    recall = 1'b1; bk = 5'd0; nf = 5'd3;
    step();
    chk("recall_count", o_count, 2);
    idle();
    recall = 1'b1; bk = 5'd0; nf = 5'd3;
    step();
    chk("recall_none_count", o_count, 2);
    idle();
    disp(0, 1'b0, 6'd0, 1'b1, 6'd0, 1'b0, 32'd99, 5'd5);
    step();
    idle();
    wake(6'd11);
    step();
    idle();
    step();
    chk("recall_surv_valid", o_miq_valid, 2'b11);
    chk("recall_surv_imm1", o_miq_imm[1], 32'd2);
    idle();
    step();
    chk("recall_tail_valid", o_miq_valid, 2'b01);
    chk("recall_tail_imm", o_miq_imm[0], 32'd99);
    idle();
    disp(0, 1'b0, 6'd12, 1'b0, 6'd0, 1'b0, 32'd60, 5'd6);
    disp(1, 1'b0, 6'd12, 1'b0, 6'd0, 1'b0, 32'd61, 5'd7);
    step();
    idle();
    recall = 1'b1; bk = 5'd0; nf = 5'd6;
    step();
    chk("recall_all_count", o_count, 0);
    idle();
    disp(0, 1'b0, 6'd0, 1'b1, 6'd0, 1'b0, 32'd77, 5'd8);
    step();
    idle();
    step();
    chk("kill_all_next_valid", o_miq_valid, 2'b01);
    chk("kill_all_next_imm", o_miq_imm[0], 32'd77);

    do_reset();
    al_next = '0;
    for (int c = 0; c < 800; c++) begin
      idle();
      for (int l = 0; l < 2; l++)
        if ($urandom_range(0, 2) != 0)
          disp(l, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom, 5'd0);
      d_al[0] = al_next;
      d_al[1] = al_next + 5'(d_valid[0]);
      for (int w = 0; w < 4; w++) begin
        wb_v[w] = 1'($urandom_range(0, 1));
        wb_u[w] = $urandom_range(0, 3) != 0;
        wb_rd[w] = 6'($urandom_range(0, 7));
      end
      recall = $urandom_range(0, 24) == 0;
      bk = al_next - 5'd16;
      nf = al_next - 5'($urandom_range(0, 10));
      of = bk;
      if (!recall && mq.size() <= DEPTH - 2) al_next = al_next + 5'(d_valid[0]) + 5'(d_valid[1]);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_issue_queue.md
Name: mem_issue_queue

Overview:
In-order memory issue queue that feeds the two-lane memory stage via miq_ifc.out o_miq[2]; it is the producer end of the miq interface the memory stage consumes.
- Accepts up to 2 dispatched load/store ops per cycle and tracks operand readiness by snooping writeback buses.
- Issues up to 2 ops per cycle, oldest first, strictly in program order.
- Squashes younger-than-recall entries on if_recall.

Parameters:
DEPTH, 8, queue entries (power of two, >= 4)
N_WB, 4, number of snooped writeback ports
PREG_W, 6, physical register tag width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
d_valid  in  2  dispatch lane valid; lane 0 older than lane 1
d_mem_access_type  in  2 x mem_access_t  READ/WRITE per lane
d_imm  in  2 x 32  address offset
d_rd  in  2 x PREG_W  load destination tag
d_rs1, d_rs2  in  2 x PREG_W each  base and store-data tags
d_rs1_rdy, d_rs2_rdy  in  2 each  operand already ready at dispatch
d_al_addr  in  2 x $clog2(`AL_SIZE)  active-list index
d_ready  out  1  high when free entries >= 2
i_wb  in  wb_ifc.in [N_WB]  writeback snoop (valid, rd, uses_rd)
if_recall  in  1  recall/flush request
new_front, old_front, back  in  $clog2(`AL_SIZE) each  active-list pointers
o_miq  out  miq_ifc.out [2]  issued ops (valid, mem_access_type, imm, rd, rs1, rs2, al_addr)
o_count  out  $clog2(DEPTH)+1  occupancy, for debug and perf counters

Behaviour:
- Storage is a circular FIFO with head, tail and count registers. Pointers wrap modulo DEPTH.
- Reset (async, rst_n=0): head=tail=count=0, all entry valid bits 0, o_miq[*].valid=0, d_ready=1.
- Dispatch:
  - Honoured only when d_ready=1; lanes with d_valid=1 are written at tail, lane 0 first.
  - A lane-1-only dispatch occupies one slot.
  - Dispatch while d_ready=0 is ignored; a bench assertion flags it.
- Wakeup:
  - Each cycle, every valid i_wb with uses_rd=1 sets rs1_rdy/rs2_rdy on any entry whose tag matches rd.
  - Dispatching entries also compare against the same-cycle i_wb, so no wakeup is lost.
  - Tag 0 is always ready.
- Issue select (combinational, registered onto o_miq, 1-cycle latency):
  - Slot 0 = head entry if valid and rs1_rdy, plus rs2_rdy when it is a WRITE.
  - Slot 1 = head+1 under the same rule, and only if slot 0 issues.
  - Issued entries pop: head += n, count -= n.
  - o_miq[k].valid=0 when nothing issues for slot k.
  - Registered outputs hold their last payload when valid=0.
- Count update: count_next = count + dispatched - issued, in the same cycle. A full queue with 2 issues still reports d_ready=0 that cycle, because d_ready is computed from the registered count.
- Recall (if_recall=1):
  - An entry survives iff its al_addr is older than new_front, i.e. circular distance (al_addr - back) < (new_front - back) mod `AL_SIZE.
  - Non-survivors are invalidated.
  - Because order is preserved, the tail is set to the first killed entry and count is recomputed.
  - Dispatch in the recall cycle is dropped.
  - Ops issuing in the recall cycle still drive o_miq; the memory stage's own flush mask handles them.
  - Wakeups in the recall cycle still apply to survivors.
- Boundaries:
  - Empty: no issue.
  - DEPTH entries: d_ready=0.
  - head/tail wrap from DEPTH-1 to 0.
  - Recall with no victims leaves state unchanged.
  - Recall killing all entries sets tail=head, count=0.
  - Reset mid-issue clears o_miq valid immediately (async).

Decomposition:
- riscv_core package (riscv_core.svh) holds: mem_access_t (READ/WRITE), miq_entry_t struct (valid, type, imm, rd, rs1, rs2, rs1_rdy, rs2_rdy, al_addr), and the al_older(a, ref, back) circular-age function.
- One sub-module: miq_wakeup_cam, which holds per-entry tag compare against N_WB writeback ports and produces rdy-set vectors.

Test Plan:
- Reset, then dispatch 2 loads with ready operands (rs1=5, imm=4 and 8) -> next cycle o_miq[0] and [1] valid with imm 4/8; o_count back to 0 one cycle after issue.
- Dispatch a store with rs2=9 not ready, followed by a ready load -> nothing issues (in-order block); i_wb rd=9 uses_rd=1 -> both issue together next cycle, store in slot 0.
- Fill 8 entries with operands not ready -> d_ready=0 and o_count=8; a further dispatch is ignored; wakeup all -> 2 issue per cycle over 4 cycles, then head wraps to 0.
- back=0, new_front=3, entries with al_addr 1,2,3,4 plus if_recall -> entries 3 and 4 killed, o_count=2, tail=head+2.
- Wakeup on the same cycle as dispatch of rs1=7, i_wb rd=7 -> the entry is ready and issues the following cycle.
- Assert rst_n=0 while o_miq valid -> o_miq valid drops without a clock edge; queue empty after release.
